dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Shares the single D-cache request port between the retire stage's committed-store path and the load execution unit.
- Locks the port to one owner from grant until the cache responds, including multi-cycle misses.
- Store grant and response are combinational in the grant cycle, so the retire-side store handshake keeps its same-cycle `dcache_store_request`/`dcache_store_response` semantics.
- Loads normally win, but a saturating starvation counter forces a store grant. Mispredict flush cancels load ownership and drains the in-flight cache op silently.

Parameters:
- STARVE_LIMIT, 4, number of consecutive cycles a pending store may lose before it is forced to win.
- CNT_W, $clog2(STARVE_LIMIT+1), starvation counter width.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- st_req_i  in  1  retire stage store request (`dcache_store_request`)
- st_addr_i  in  32 (ADDR)  store address
- st_data_i  in  32 (DATA)  store data
- st_size_i  in  2 (MEM_SIZE)  store size
- st_resp_o  out  1  store done (`dcache_store_response`)
- ld_req_i  in  1  load request
- ld_addr_i  in  32 (ADDR)  load address
- ld_size_i  in  2 (MEM_SIZE)  load size
- ld_resp_o  out  1  load done pulse
- ld_data_o  out  32 (DATA)  load data, valid with ld_resp_o
- flush_i  in  1  mispredict flush
- cache_req_o  out  1  request to D-cache
- cache_we_o  out  1  1 = store
- cache_addr_o  out  32  address to D-cache
- cache_wdata_o  out  32  write data to D-cache
- cache_size_o  out  2  access size to D-cache
- cache_resp_i  in  1  D-cache done; may assert in the request cycle
- cache_rdata_i  in  32  read data, valid with cache_resp_i
- busy_o  out  1  state != IDLE
- starve_cnt_o  out  CNT_W  current starvation count (debug)

Behaviour:
- **States:** IDLE, LOCK_ST, LOCK_LD, DRAIN_LD. All state is registered.
- **Reset:** state = IDLE, latched request = 0, starve counter = 0. With no requests, every output reads 0.
- Reset mid-operation abandons the in-flight op; the D-cache is reset in the same cycle.
- **IDLE winner selection (combinational):**
  - Store wins if st_req_i && (!ld_req_i || flush_i || starve_cnt == STARVE_LIMIT).
  - Otherwise load wins if ld_req_i && !flush_i.
  - Otherwise there is no grant.
- **IDLE drive:** the winner's payload goes straight to the cache port in the same cycle (cache_we_o = 1 for a store). A load winner drives cache_wdata_o = 0.
- **IDLE response:** if cache_resp_i is high in that cycle, pulse the winner's resp combinationally and stay in IDLE.
- **IDLE latch:** if cache_resp_i is low, latch {we, addr, wdata, size} and go to LOCK_ST or LOCK_LD.
- **LOCK_ST / LOCK_LD:**
  - cache_req_o = 1, driven from the latched payload; input payload changes are ignored.
  - On cache_resp_i, pulse the owner's resp (combinational) and go to IDLE. No new grant is made in that same cycle.
- **st_req_i drop during LOCK_ST:** illegal, because a committed store cannot be withdrawn; the bench asserts against it. The RTL still completes the op.
- **Flush:**
  - Flush in LOCK_LD without cache_resp_i: go to DRAIN_LD.
  - Flush in LOCK_LD together with cache_resp_i: go to IDLE with ld_resp_o suppressed.
  - Flush in IDLE: blocks load grant only; stores are committed and are never flushed.
  - Flush in LOCK_ST: no effect.
- **DRAIN_LD:** cache_req_o = 1 from the latched payload. ld_resp_o stays 0. On cache_resp_i go to IDLE. A second flush has no effect.
- **ld_data_o:** equals cache_rdata_i when ld_resp_o = 1, otherwise 0.
- **Starvation counter:**
  - Cleared to 0 when st_req_i is low or a store is granted.
  - Otherwise incremented, saturating at STARVE_LIMIT, on every cycle st_req_i is high without a store grant. This includes cycles spent in LOCK_LD and DRAIN_LD.
- **Forced store at the limit:** when starve_cnt == STARVE_LIMIT in IDLE, the store wins even with ld_req_i high. The counter clears on that grant.
- **Invariants:**
  - st_resp_o and ld_resp_o are never high together.
  - cache_req_o is low only in IDLE with no winner.
- **Latency:** hit = 0 extra cycles (response in the request cycle); miss = cache latency, with no added arbiter cycles.

Decomposition:
- Shared package (sys_defs.svh):
  - DCACHE_ARB_STATE enum {IDLE, LOCK_ST, LOCK_LD, DRAIN_LD}.
  - DCACHE_PORT_REQ struct {we, ADDR addr, DATA wdata, MEM_SIZE size}.
  - `DCACHE_STARVE_LIMIT define feeding the parameter. The existing ADDR, DATA and MEM_SIZE types are reused.
- Single module, no sub-module. The starvation counter and the latch are inline.

Test Plan:
- **Store hit:** st_req=1 with addr=0x100, data=0xDEADBEEF, cache_resp same cycle -> cache_we_o=1, cache_addr_o=0x100, st_resp_o=1 that cycle, state stays IDLE.
- **Load miss, held 3 cycles:** load at 0x200; change ld_addr_i to 0x300 in cycle 1; cache_resp arrives in cycle 3 with rdata=0x1234 -> cache_addr_o stays 0x200 throughout, ld_resp_o=1 and ld_data_o=0x1234 only in cycle 3.
- **Starvation:** ld_req and st_req held high, every load hits -> loads granted for 4 cycles, starve_cnt_o goes 1..4, store granted in cycle 5, counter returns to 0.
- **Flush during load miss:** flush in LOCK_LD -> DRAIN_LD, cache_req_o stays 1; resp 2 cycles later -> ld_resp_o stays 0, state returns to IDLE. A store arriving meanwhile is granted only in the cycle after the return to IDLE.
- **Flush in IDLE with both requesting:** st_req, ld_req and flush_i high in IDLE -> store granted, load not; flush in LOCK_ST leaves st_resp_o unaffected.
- **Reset mid-op:** reset asserted in LOCK_LD -> next cycle state=IDLE, cache_req_o=0, starve_cnt_o=0, no resp pulse.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the D-cache port arbiter: address/data types, arbiter
// states and the request payload that is latched while a cache op is in flight.
package dcache_port_arbiter_pkg;

    typedef logic [31:0] ADDR;
    typedef logic [31:0] DATA;
    typedef logic [1:0]  MEM_SIZE;

    localparam int DCACHE_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_ST  = 2'd1,
        LOCK_LD  = 2'd2,
        DRAIN_LD = 2'd3
    } DCACHE_ARB_STATE;

    typedef struct packed {
        logic    we;
        ADDR     addr;
        DATA     wdata;
        MEM_SIZE size;
    } DCACHE_PORT_REQ;

    function automatic DCACHE_PORT_REQ make_port_req(
        input logic    we,
        input ADDR     addr,
        input DATA     wdata,
        input MEM_SIZE size
    );
        DCACHE_PORT_REQ r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        r.size  = size;
        return r;
    endfunction

endpackage

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single D-cache port between committed stores and loads.
// The port stays owned from grant until the cache responds; flush drains loads.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DCACHE_STARVE_LIMIT,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             st_req_i,
    input  logic [31:0]      st_addr_i,
    input  logic [31:0]      st_data_i,
    input  logic [1:0]       st_size_i,
    output logic             st_resp_o,
    input  logic             ld_req_i,
    input  logic [31:0]      ld_addr_i,
    input  logic [1:0]       ld_size_i,
    output logic             ld_resp_o,
    output logic [31:0]      ld_data_o,
    input  logic             flush_i,
    output logic             cache_req_o,
    output logic             cache_we_o,
    output logic [31:0]      cache_addr_o,
    output logic [31:0]      cache_wdata_o,
    output logic [1:0]       cache_size_o,
    input  logic             cache_resp_i,
    input  logic [31:0]      cache_rdata_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] starve_cnt_o
);

    DCACHE_ARB_STATE state_r, state_next_s;
    DCACHE_PORT_REQ  lat_r;
    DCACHE_PORT_REQ  port_s;
    logic [CNT_W-1:0] starve_cnt_r, starve_cnt_next_s;
    logic store_win_s, load_win_s, starve_at_limit_s;
    logic latch_en_s, store_owns_s;
    logic st_resp_s, ld_resp_s, cache_req_s;

    assign starve_at_limit_s = (starve_cnt_r == CNT_W'(STARVE_LIMIT));

    // IDLE winner selection: loads win unless absent, flushed, or the store has starved
    always_comb begin
        store_win_s = 1'b0;
        load_win_s  = 1'b0;
        if (state_r == IDLE) begin
            store_win_s = st_req_i && (!ld_req_i || flush_i || starve_at_limit_s);
            load_win_s  = !store_win_s && ld_req_i && !flush_i;
        end else begin
            store_win_s = 1'b0;
            load_win_s  = 1'b0;
        end
    end

    // Next-state logic; a response in a locked state never chains into a new grant
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (store_win_s && !cache_resp_i) begin
                    state_next_s = LOCK_ST;
                end else if (load_win_s && !cache_resp_i) begin
                    state_next_s = LOCK_LD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOCK_ST: begin
                if (cache_resp_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LOCK_ST;
                end
            end
            LOCK_LD: begin
                if (cache_resp_i) begin
                    state_next_s = IDLE;
                end else if (flush_i) begin
                    state_next_s = DRAIN_LD;
                end else begin
                    state_next_s = LOCK_LD;
                end
            end
            DRAIN_LD: begin
                if (cache_resp_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN_LD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic: IDLE forwards the winner's payload, locked states replay the latch
    always_comb begin
        port_s      = '0;
        cache_req_s = 1'b0;
        st_resp_s   = 1'b0;
        ld_resp_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (store_win_s) begin
                    port_s      = make_port_req(1'b1, st_addr_i, st_data_i, st_size_i);
                    cache_req_s = 1'b1;
                    st_resp_s   = cache_resp_i;
                end else if (load_win_s) begin
                    port_s      = make_port_req(1'b0, ld_addr_i, 32'h0000_0000, ld_size_i);
                    cache_req_s = 1'b1;
                    ld_resp_s   = cache_resp_i;
                end else begin
                    port_s      = '0;
                    cache_req_s = 1'b0;
                end
            end
            LOCK_ST: begin
                port_s      = lat_r;
                cache_req_s = 1'b1;
                st_resp_s   = cache_resp_i;
            end
            LOCK_LD: begin
                port_s      = lat_r;
                cache_req_s = 1'b1;
                ld_resp_s   = cache_resp_i && !flush_i;
            end
            DRAIN_LD: begin
                port_s      = lat_r;
                cache_req_s = 1'b1;
            end
            default: begin
                port_s      = '0;
                cache_req_s = 1'b0;
            end
        endcase
    end

    assign latch_en_s   = (store_win_s || load_win_s) && !cache_resp_i;
    assign store_owns_s = store_win_s || (state_r == LOCK_ST);

    // Starvation counter: a pending store that does not hold the port ages, saturating
    always_comb begin
        starve_cnt_next_s = starve_cnt_r;
        if (!st_req_i || store_owns_s) begin
            starve_cnt_next_s = '0;
        end else if (!starve_at_limit_s) begin
            starve_cnt_next_s = starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_next_s = starve_cnt_r;
        end
    end

    // State, payload latch and starvation counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            lat_r        <= '0;
            starve_cnt_r <= '0;
        end else begin
            state_r      <= state_next_s;
            starve_cnt_r <= starve_cnt_next_s;
            if (latch_en_s) begin
                lat_r <= port_s;
            end
        end
    end

    // Port drive; reset silences everything because the cache is reset in the same cycle
    always_comb begin
        if (reset) begin
            cache_req_o   = 1'b0;
            cache_we_o    = 1'b0;
            cache_addr_o  = 32'h0000_0000;
            cache_wdata_o = 32'h0000_0000;
            cache_size_o  = 2'b00;
            st_resp_o     = 1'b0;
            ld_resp_o     = 1'b0;
            ld_data_o     = 32'h0000_0000;
            busy_o        = 1'b0;
            starve_cnt_o  = '0;
        end else begin
            cache_req_o   = cache_req_s;
            cache_we_o    = port_s.we;
            cache_addr_o  = port_s.addr;
            cache_wdata_o = port_s.wdata;
            cache_size_o  = port_s.size;
            st_resp_o     = st_resp_s;
            ld_resp_o     = ld_resp_s;
            ld_data_o     = ld_resp_s ? cache_rdata_i : 32'h0000_0000;
            busy_o        = (state_r != IDLE);
            starve_cnt_o  = starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: directed scenarios plus random
// traffic, predicted by a port-ownership model and checked by a separate monitor.
module tb_dcache_port_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        st_req_i, ld_req_i, flush_i, cache_resp_i;
    logic [31:0] st_addr_i, st_data_i, ld_addr_i, cache_rdata_i;
    logic [1:0]  st_size_i, ld_size_i;
    logic        st_resp_o, ld_resp_o, cache_req_o, cache_we_o, busy_o;
    logic [31:0] ld_data_o, cache_addr_o, cache_wdata_o;
    logic [1:0]  cache_size_o;
    logic [2:0]  starve_cnt_o;

    dcache_port_arbiter dut (
        .clock(clock), .reset(reset),
        .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_size_i(st_size_i), .st_resp_o(st_resp_o),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_size_i(ld_size_i),
        .ld_resp_o(ld_resp_o), .ld_data_o(ld_data_o), .flush_i(flush_i),
        .cache_req_o(cache_req_o), .cache_we_o(cache_we_o), .cache_addr_o(cache_addr_o),
        .cache_wdata_o(cache_wdata_o), .cache_size_o(cache_size_o),
        .cache_resp_i(cache_resp_i), .cache_rdata_i(cache_rdata_i),
        .busy_o(busy_o), .starve_cnt_o(starve_cnt_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        st_resp;
        logic        ld_resp;
        logic [31:0] ld_data;
        logic        busy;
        logic [2:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: who holds the port (0 free, 1 store, 2 load, 3 cancelled load) and what it sent
    int          owner = 0;
    int          starve = 0;
    logic        own_we;
    logic [31:0] own_addr, own_wdata;
    logic [1:0]  own_size;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    endtask

    // Monitor: pops one prediction per cycle and compares away from the active edge
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("cache_req", {31'd0, cache_req_o}, {31'd0, e.req});
            check("cache_we", {31'd0, cache_we_o}, {31'd0, e.we});
            check("cache_addr", cache_addr_o, e.addr);
            check("cache_wdata", cache_wdata_o, e.wdata);
            check("cache_size", {30'd0, cache_size_o}, {30'd0, e.size});
            check("st_resp", {31'd0, st_resp_o}, {31'd0, e.st_resp});
            check("ld_resp", {31'd0, ld_resp_o}, {31'd0, e.ld_resp});
            check("ld_data", ld_data_o, e.ld_data);
            check("busy", {31'd0, busy_o}, {31'd0, e.busy});
            check("starve_cnt", {29'd0, starve_cnt_o}, {29'd0, e.cnt});
        end
    end

    // Drive one cycle of inputs, predict the DUT response from port-ownership rules, push it
    task automatic cyc(input logic st, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [1:0] ss, input logic ld, input logic [31:0] la,
                       input logic [1:0] ls, input logic fl, input logic cr,
                       input logic [31:0] rd, input logic rs);
        exp_t e;
        logic st_wins, ld_wins, store_holds;
        @(posedge clock);
        #1;
        reset = rs; st_req_i = st; st_addr_i = sa; st_data_i = sd; st_size_i = ss;
        ld_req_i = ld; ld_addr_i = la; ld_size_i = ls; flush_i = fl;
        cache_resp_i = cr; cache_rdata_i = rd;
        assert (rs || owner != 1 || st)
            else $error("FAIL protocol: committed store withdrawn while owning the port");
        e = '0;
        st_wins = 1'b0;
        ld_wins = 1'b0;
        if (rs) begin
            owner  = 0;
            starve = 0;
        end else begin
            e.busy = (owner != 0);
            e.cnt  = 3'(starve);
            store_holds = (owner == 1);
            if (owner == 0) begin
                st_wins = st && (!ld || fl || starve == LIMIT);
                ld_wins = !st_wins && ld && !fl;
                if (st_wins) begin
                    e.req = 1'b1; e.we = 1'b1; e.addr = sa; e.wdata = sd; e.size = ss;
                    e.st_resp = cr;
                end else if (ld_wins) begin
                    e.req = 1'b1; e.addr = la; e.size = ls;
                    e.ld_resp = cr;
                    e.ld_data = cr ? rd : 32'h0;
                end
                if ((st_wins || ld_wins) && !cr) begin
                    owner = st_wins ? 1 : 2;
                    own_we = e.we; own_addr = e.addr; own_wdata = e.wdata; own_size = e.size;
                end
            end else begin
                e.req = 1'b1; e.we = own_we; e.addr = own_addr;
                e.wdata = own_wdata; e.size = own_size;
                if (cr) begin
                    e.st_resp = (owner == 1);
                    e.ld_resp = (owner == 2) && !fl;
                    e.ld_data = e.ld_resp ? rd : 32'h0;
                    owner = 0;
                end else if (owner == 2 && fl) begin
                    owner = 3;
                end
            end
            if (!st || st_wins || store_holds) starve = 0;
            else if (starve < LIMIT) starve = starve + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle_cyc(input logic cr);
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, cr, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; st_req_i = 1'b0; ld_req_i = 1'b0; flush_i = 1'b0; cache_resp_i = 1'b0;
        st_addr_i = 32'h0; st_data_i = 32'h0; ld_addr_i = 32'h0; cache_rdata_i = 32'h0;
        st_size_i = 2'd0; ld_size_i = 2'd0;
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle_cyc(1'b0);
        // Store hit in the request cycle
        cyc(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
        idle_cyc(1'b0);
        // Load miss: payload change ignored, response in the third cycle
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h200, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h300, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h300, 2'd1, 1'b0, 1'b0, 32'h55, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h300, 2'd1, 1'b0, 1'b1, 32'h1234, 1'b0);
        // Starvation: four load hits, then the forced store
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 32'h400, 32'hA5A5_0000 + 32'(i), 2'd2, 1'b1, 32'h500 + 32'(i), 2'd2,
                1'b0, 1'b1, 32'h77 + 32'(i), 1'b0);
        idle_cyc(1'b0);
        // Flush during load miss, store waits through the drain
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h600, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h700, 32'h1111, 2'd2, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h700, 32'h1111, 2'd2, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h99, 1'b0);
        cyc(1'b1, 32'h700, 32'h1111, 2'd2, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
        // Flush in IDLE with both requesting, then flush during the store lock
        cyc(1'b1, 32'h800, 32'h2222, 2'd1, 1'b1, 32'h900, 2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h0, 32'h0, 2'd0, 1'b1, 32'h900, 2'd1, 1'b1, 1'b1, 32'h0, 1'b0);
        // Reset while a load miss is outstanding
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hA00, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hA00, 2'd2, 1'b0, 1'b1, 32'h5, 1'b1);
        idle_cyc(1'b1);
        // Random traffic; a store that holds the port keeps requesting
        for (int i = 0; i < 600; i++) begin
            logic st, ld, fl, cr, rs;
            st = (owner == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            ld = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 7) == 0);
            cr = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 99) == 0);
            cyc(st, $urandom, $urandom, 2'($urandom_range(0, 3)), ld, $urandom,
                2'($urandom_range(0, 3)), fl, cr, $urandom, rs);
        end
        idle_cyc(1'b1);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
        #6;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain_timeout: %0d predictions left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
